// File: rtl/prbs_chk.sv
// prbs_chk: serial PRBS checker (receive end of a PRBS pattern link).
//
// The checker loads PLEN received bits into a Fibonacci LFSR (HUNT) and then
// checks LOCK_CNT consecutive predicted bits (VERIFY). After that it declares
// lock and runs the LFSR free from its own prediction (LOCKED). While locked
// it flags and counts every mismatched bit. It drops lock when UNLOCK_ERR
// errors fall inside one WIN-bit window.
//
// Ports:
//   cp_i      clock, rising edge
//   nrst_i    asynchronous active-low reset
//   en_i      bit-valid qualifier; nothing advances while low
//   d_i       received serial bit
//   clr_i     synchronous clear of errcnt_o / sat_o (acts on valid cycles)
//   lock_o    registered, high while LOCKED
//   err_o     registered one-cycle pulse per mismatched bit while LOCKED
//   errcnt_o  saturating error count (ERRW bits)
//   sat_o     sticky, set once errcnt_o reaches all-ones
//
// Build option: define PRBS_CHK_INV_EN to invert d_i before any use, which
// supports a PRBS source of inverted polarity.

module prbs_chk #(
    parameter int unsigned PLEN       = 7,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned WIN        = 64,
    parameter int unsigned UNLOCK_ERR = 4,
    parameter int unsigned ERRW       = 16
) (
    input  logic            cp_i,
    input  logic            nrst_i,
    input  logic            en_i,
    input  logic            d_i,
    input  logic            clr_i,
    output logic            lock_o,
    output logic            err_o,
    output logic [ERRW-1:0] errcnt_o,
    output logic            sat_o
);

    // Second tap of each supported polynomial. The first tap is always PLEN.
    localparam int unsigned TAP2 = (PLEN == 7)  ? 6  :
                                   (PLEN == 15) ? 14 :
                                   (PLEN == 23) ? 18 :
                                   (PLEN == 31) ? 28 : 0;
    localparam int unsigned FillW = $clog2(PLEN + 1);

    if (TAP2 == 0) begin : g_bad_plen
        $error("prbs_chk: PLEN must be 7, 15, 23 or 31");
    end
    if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
        $error("prbs_chk: LOCK_CNT must be in 1..255");
    end
    if (WIN < 2 || WIN > 65535) begin : g_bad_win
        $error("prbs_chk: WIN must be in 2..65535");
    end
    if (UNLOCK_ERR < 1 || UNLOCK_ERR > WIN) begin : g_bad_unlock_err
        $error("prbs_chk: UNLOCK_ERR must be in 1..WIN");
    end
    if (ERRW < 1) begin : g_bad_errw
        $error("prbs_chk: ERRW must be at least 1");
    end

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } state_e;

    state_e            state_q, state_d;
    logic [PLEN-1:0]   lfsr_q, lfsr_d;
    logic [FillW-1:0]  fill_q, fill_d;
    logic [7:0]        match_q, match_d;
    logic [15:0]       win_cnt_q, win_cnt_d;
    logic [15:0]       win_err_q, win_err_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic [ERRW-1:0]   errcnt_q, errcnt_d;
    logic              sat_q, sat_d;

    logic              din;
    logic              pred;
    logic              mismatch;
    logic              cnt_inc;
    logic [PLEN-1:0]   lfsr_din;
    logic [PLEN-1:0]   lfsr_pred;
    logic [15:0]       win_err_nx;

`ifdef PRBS_CHK_INV_EN
    assign din = ~d_i;
`else
    assign din = d_i;
`endif

    assign pred       = lfsr_q[PLEN-1] ^ lfsr_q[TAP2-1];
    assign mismatch   = din ^ pred;
    assign lfsr_din   = {lfsr_q[PLEN-2:0], din};
    assign lfsr_pred  = {lfsr_q[PLEN-2:0], pred};
    assign win_err_nx = win_err_q + 16'(mismatch);

    // Lock/verify FSM and LFSR.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        lock_d    = lock_q;
        err_d     = 1'b0;
        cnt_inc   = 1'b0;

        if (en_i) begin
            case (state_q)
                StHunt: begin
                    lfsr_d = lfsr_din;
                    if (fill_q == FillW'(PLEN - 1)) begin
                        fill_d = '0;
                        // An all-zero load is the LFSR lock-up state; refill.
                        if (lfsr_din != '0) begin
                            state_d = StVerify;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + FillW'(1);
                    end
                end

                StVerify: begin
                    lfsr_d = lfsr_din;
                    if (mismatch) begin
                        state_d = StHunt;
                        fill_d  = '0;
                    end else if (match_q == 8'(LOCK_CNT - 1)) begin
                        state_d   = StLocked;
                        lock_d    = 1'b1;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end

                StLocked: begin
                    // Free-run on the prediction so line errors cannot
                    // corrupt the reference sequence.
                    lfsr_d  = lfsr_pred;
                    err_d   = mismatch;
                    cnt_inc = mismatch;
                    if (win_err_nx == 16'(UNLOCK_ERR)) begin
                        state_d = StHunt;
                        lock_d  = 1'b0;
                        fill_d  = '0;
                    end else if (win_cnt_q == 16'(WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 16'd1;
                        win_err_d = win_err_nx;
                    end
                end

                default: begin
                    state_d = StHunt;
                    lock_d  = 1'b0;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Saturating error counter. clr_i wins over an increment in the same
    // cycle. Like every other register, the counter holds while en_i is low.
    always_comb begin
        errcnt_d = errcnt_q;
        sat_d    = sat_q;
        if (en_i) begin
            if (clr_i) begin
                errcnt_d = '0;
                sat_d    = 1'b0;
            end else begin
                if (cnt_inc && !(&errcnt_q)) begin
                    errcnt_d = errcnt_q + ERRW'(1);
                end
                sat_d = sat_q | (&errcnt_d);
            end
        end
    end

    always_ff @(posedge cp_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q   <= StHunt;
            lfsr_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            errcnt_q  <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            errcnt_q  <= errcnt_d;
            sat_q     <= sat_d;
        end
    end

    assign lock_o   = lock_q;
    assign err_o    = err_q;
    assign errcnt_o = errcnt_q;
    assign sat_o    = sat_q;

endmodule

// File: tb/tb_prbs_chk.sv
// Self-checking bench for prbs_chk. Two instances share the stimulus: one
// uses the default 16-bit error counter and one uses a 4-bit counter, which
// exercises saturation.

module tb_prbs_chk;

    localparam int unsigned PLEN       = 7;
    localparam int unsigned TAP2       = 6;
    localparam int unsigned LOCK_CNT   = 16;
    localparam int unsigned WIN        = 64;
    localparam int unsigned UNLOCK_ERR = 4;

    localparam int MHunt   = 0;
    localparam int MVerify = 1;
    localparam int MLocked = 2;

    logic        cp;
    logic        nrst, en, d, clr;
    logic        lock16, err16, sat16;
    logic [15:0] cnt16;
    logic        lock4, err4, sat4;
    logic [3:0]  cnt4;

    initial cp = 1'b0;
    always #5 cp = ~cp;

    prbs_chk #(
        .PLEN(PLEN), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERR(UNLOCK_ERR), .ERRW(16)
    ) dut (
        .cp_i(cp), .nrst_i(nrst), .en_i(en), .d_i(d), .clr_i(clr),
        .lock_o(lock16), .err_o(err16), .errcnt_o(cnt16), .sat_o(sat16)
    );

    prbs_chk #(
        .PLEN(PLEN), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERR(UNLOCK_ERR), .ERRW(4)
    ) dut_sat (
        .cp_i(cp), .nrst_i(nrst), .en_i(en), .d_i(d), .clr_i(clr),
        .lock_o(lock4), .err_o(err4), .errcnt_o(cnt4), .sat_o(sat4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          lock;
        bit          err;
        int unsigned c16;
        bit          s16;
        int unsigned c4;
        bit          s4;
    } exp_t;

    exp_t        exp_q[$];
    int          m_mode;
    bit          m_hist[$];   // last PLEN reference bits, oldest first
    int          m_run, m_wbits, m_werrs;
    bit          m_lock, m_err, m_s16, m_s4;
    int unsigned m_c16, m_c4;

    function automatic void model_reset();
        m_mode = MHunt;
        m_hist.delete();
        m_run = 0; m_wbits = 0; m_werrs = 0;
        m_lock = 0; m_err = 0;
        m_c16 = 0; m_c4 = 0; m_s16 = 0; m_s4 = 0;
    endfunction

    function automatic void model_step(bit nr, bit e, bit b, bit c);
        bit din, pred, mis, allz;
        if (!nr) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (!e) return;
`ifdef PRBS_CHK_INV_EN
        din = ~b;
`else
        din = b;
`endif
        if (c) begin
            m_c16 = 0; m_c4 = 0; m_s16 = 0; m_s4 = 0;
        end
        case (m_mode)
            MHunt: begin
                m_hist.push_back(din);
                if (m_hist.size() == PLEN) begin
                    allz = 1;
                    foreach (m_hist[i]) if (m_hist[i]) allz = 0;
                    if (allz) m_hist.delete();
                    else begin
                        m_mode = MVerify;
                        m_run  = 0;
                    end
                end
            end
            MVerify: begin
                pred = m_hist[0] ^ m_hist[PLEN-TAP2];
                m_hist.push_back(din);
                void'(m_hist.pop_front());
                if (din == pred) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_mode = MLocked; m_lock = 1; m_wbits = 0; m_werrs = 0;
                    end
                end else begin
                    m_mode = MHunt;
                    m_hist.delete();
                end
            end
            default: begin
                pred = m_hist[0] ^ m_hist[PLEN-TAP2];
                m_hist.push_back(pred);
                void'(m_hist.pop_front());
                mis   = (din != pred);
                m_err = mis;
                if (mis && !c) begin
                    if (m_c16 < 65535) m_c16++;
                    if (m_c4 < 15) m_c4++;
                end
                m_wbits++;
                if (mis) m_werrs++;
                if (m_werrs == UNLOCK_ERR) begin
                    m_mode = MHunt; m_lock = 0; m_hist.delete();
                end else if (m_wbits == WIN) begin
                    m_wbits = 0; m_werrs = 0;
                end
            end
        endcase
        if (m_c16 == 65535) m_s16 = 1;
        if (m_c4 == 15) m_s4 = 1;
    endfunction

    // ---------------- PRBS7 source ----------------
    bit g_state[$];

    function automatic void gen_reset();
        g_state.delete();
        repeat (PLEN) g_state.push_back(1'b1);  // seed 7'h7F
    endfunction

    function automatic bit gen_next();
        bit nb;
        nb = g_state[0] ^ g_state[PLEN-TAP2];
        g_state.push_back(nb);
        void'(g_state.pop_front());
        return nb;
    endfunction

    // ---------------- driver ----------------
    bit gaps = 0;

    task automatic cycle(input bit nr, input bit e, input bit b, input bit c);
        @(negedge cp);
        nrst = nr; en = e; d = b; clr = c;
        model_step(nr, e, b, c);
        exp_q.push_back('{m_lock, m_err, m_c16, m_s16, m_c4, m_s4});
    endtask

    // One valid bit (optionally preceded by an en gap); returns at a sampling point.
    task automatic send(input bit b, input bit c);
        if (gaps) repeat ($urandom_range(0, 3)) cycle(1'b1, 1'b0, 1'($urandom), 1'b0);
        cycle(1'b1, 1'b1, b, c);
        @(posedge cp);
        #1;
    endtask

    task automatic do_reset();
        repeat (3) cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge cp);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("lock", 32'(lock16), 32'(e.lock));
                check("err", 32'(err16), 32'(e.err));
                check("errcnt", 32'(cnt16), e.c16);
                check("sat", 32'(sat16), 32'(e.s16));
                check("lock_w4", 32'(lock4), 32'(e.lock));
                check("err_w4", 32'(err4), 32'(e.err));
                check("errcnt_w4", 32'(cnt4), e.c4);
                check("sat_w4", 32'(sat4), 32'(e.s4));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        nrst = 1'b0; en = 1'b0; d = 1'b0; clr = 1'b0;
        model_reset();

        // Reset with toggling inputs, then idle with en low.
        repeat (6) cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'($urandom), 1'b0);
        @(posedge cp); #1;
        check("idle_lock", 32'(lock16), 0);
        check("idle_errcnt", 32'(cnt16), 0);

        // Clean PRBS7: lock rises on valid bit PLEN+LOCK_CNT.
        gen_reset();
        for (int i = 1; i <= 300; i++) begin
            send(gen_next(), 1'b0);
            if (i == 22) check("clean_lock_early", 32'(lock16), 0);
            if (i == 23) check("clean_lock_point", 32'(lock16), 1);
        end
        check("clean_errcnt", 32'(cnt16), 0);

        // Single error at bit 100.
        do_reset();
        gen_reset();
        for (int i = 1; i <= 300; i++) begin
            send(gen_next() ^ (i == 100), 1'b0);
            if (i == 100) check("single_err_pulse", 32'(err16), 1);
        end
        check("single_errcnt", 32'(cnt16), 1);
        check("single_lock", 32'(lock16), 1);

        // Burst of 4 errors in one window drops lock; clean data relocks.
        do_reset();
        gen_reset();
        for (int i = 1; i <= 250; i++) begin
            send(gen_next() ^ (i == 100 || i == 110 || i == 120 || i == 130), 1'b0);
            if (i == 129) check("burst_lock_held", 32'(lock16), 1);
            if (i == 130) begin
                check("burst_unlock", 32'(lock16), 0);
                check("burst_4th_err", 32'(err16), 1);
                check("burst_errcnt", 32'(cnt16), 4);
            end
            if (i == 152) check("burst_relock_early", 32'(lock16), 0);
            if (i == 153) check("burst_relock", 32'(lock16), 1);
        end
        check("burst_errcnt_kept", 32'(cnt16), 4);

        // en gaps, then clr while locked.
        do_reset();
        gen_reset();
        gaps = 1;
        for (int i = 1; i <= 120; i++) begin
            send(gen_next() ^ (i == 50 || i == 60 || i == 70), i == 81);
            if (i == 22) check("gap_lock_early", 32'(lock16), 0);
            if (i == 23) check("gap_lock_point", 32'(lock16), 1);
            if (i == 80) check("gap_errcnt", 32'(cnt16), 3);
            if (i == 81) begin
                check("clr_errcnt", 32'(cnt16), 0);
                check("clr_lock", 32'(lock16), 1);
            end
        end
        gaps = 0;

        // Saturation: one error per window, 20 windows.
        do_reset();
        gen_reset();
        for (int i = 1; i <= 1260; i++) begin
            send(gen_next() ^ (i >= 34 && i <= 1250 && ((i - 34) % 64) == 0), 1'b0);
        end
        check("sat_errcnt_w4", 32'(cnt4), 15);
        check("sat_flag_w4", 32'(sat4), 1);
        check("sat_errcnt_w16", 32'(cnt16), 20);
        check("sat_flag_w16", 32'(sat16), 0);
        check("sat_lock", 32'(lock4), 1);
        send(gen_next(), 1'b1);
        check("sat_clr_errcnt", 32'(cnt4), 0);
        check("sat_clr_flag", 32'(sat4), 0);

        // Inverted stream (model decides whether it may lock).
        do_reset();
        gen_reset();
        for (int i = 1; i <= 200; i++) send(~gen_next(), 1'b0);

        // Randomised: gaps, sparse and bursty errors, clr, a mid-run reset.
        do_reset();
        gen_reset();
        gaps = 1;
        for (int i = 1; i <= 2500; i++) begin
            bit flip;
            flip = ($urandom_range(0, 99) < ((i / 500) % 2 == 1 ? 8 : 2));
            send(gen_next() ^ flip, $urandom_range(0, 99) == 0);
            if (i == 1300) do_reset();
        end
        gaps = 0;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge cp);
        #2;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
